// File: rtl/mult8_pkg.sv
// Shared types and constants for the 8x8 shift-add multiplier.
// Also provides the 4-bit carry-lookahead slice used by the adder datapath.
package mult8_pkg;

  localparam int unsigned WIDTH = 8;
  localparam logic [2:0] ITER_LAST = 3'd7;

  typedef enum logic [2:0] {IDLE, CLR, ADD, SHIFT, DONE} state_t;

  // Returns {carry_out, sum[3:0]}; carries are computed from g/p directly, not rippled.
  function automatic logic [4:0] cla4(input logic [3:0] a, input logic [3:0] b,
                                      input logic cin);
    logic [3:0] g;
    logic [3:0] p;
    logic [4:0] c;
    g    = a & b;
    p    = a ^ b;
    c[0] = cin;
    c[1] = g[0] | (p[0] & cin);
    c[2] = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
    c[3] = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & cin);
    c[4] = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1]) | (p[3] & p[2] & p[1] & g[0])
         | (p[3] & p[2] & p[1] & p[0] & cin);
    return {c[4], p ^ c[3:0]};
  endfunction

endpackage

// File: rtl/mult8_shift_add_if.sv
// Switch/button and register-readback bundle for mult8_shift_add.
interface mult8_shift_add_if;
  import mult8_pkg::*;

  logic             Run;
  logic             ClearA_LoadB;
  logic [WIDTH-1:0] S;
  logic [WIDTH-1:0] Aval;
  logic [WIDTH-1:0] Bval;
  logic             Xval;
  logic             Busy;

  modport master (output Run, ClearA_LoadB, S, input Aval, Bval, Xval, Busy);
  modport slave  (input Run, ClearA_LoadB, S, output Aval, Bval, Xval, Busy);
endinterface

// File: rtl/add_sub9.sv
// 9-bit combinational add/subtract: two 4-bit lookahead slices plus a top bit.
module add_sub9
  import mult8_pkg::*;
(
  input  logic [8:0] a,
  input  logic [8:0] b,
  input  logic       sub,
  output logic [8:0] sum
);

  logic [8:0] bx;
  logic [4:0] lo;
  logic [4:0] hi;

  // Subtract as a + ~b + 1, with the +1 entering as the low slice carry-in.
  assign bx  = b ^ {9{sub}};
  assign lo  = cla4(a[3:0], bx[3:0], sub);
  assign hi  = cla4(a[7:4], bx[7:4], lo[4]);
  assign sum = {a[8] ^ bx[8] ^ hi[4], hi[3:0], lo[3:0]};

endmodule

// File: rtl/mult8_shift_add.sv
// Sequential 8x8 shift-add multiplier; product in {A,B}, sign-extension bit in X.
// Define MULT_SIGNED_EN for two's-complement operation; default build is unsigned.
module mult8_shift_add
  import mult8_pkg::*;
(
  input  logic               Clk,
  input  logic               Reset,
  mult8_shift_add_if.slave   bus
);

  state_t           state_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] m_q;
  logic             x_q;
  logic [2:0]       cnt_q;
  logic             busy_q;

  logic [8:0]       add_a;
  logic [8:0]       add_b;
  logic             add_sub;
  logic [8:0]       sum_d;
  logic             shift_x_d;

`ifdef MULT_SIGNED_EN
  assign add_a     = {a_q[WIDTH-1], a_q};
  assign add_b     = {m_q[WIDTH-1], m_q};
  assign add_sub   = (cnt_q == ITER_LAST);
  assign shift_x_d = x_q;
`else
  assign add_a     = {1'b0, a_q};
  assign add_b     = {1'b0, m_q};
  assign add_sub   = 1'b0;
  assign shift_x_d = 1'b0;
`endif

  add_sub9 u_add_sub9 (
    .a   (add_a),
    .b   (add_b),
    .sub (add_sub),
    .sum (sum_d)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= '0;
      x_q     <= 1'b0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.Run) begin
            state_q <= CLR;
            busy_q  <= 1'b1;
          end else if (bus.ClearA_LoadB) begin
            b_q <= bus.S;
            a_q <= '0;
            x_q <= 1'b0;
          end
        end
        CLR: begin
          m_q     <= bus.S;
          a_q     <= '0;
          x_q     <= 1'b0;
          cnt_q   <= '0;
          state_q <= ADD;
        end
        ADD: begin
          if (b_q[0]) {x_q, a_q} <= sum_d;
          state_q <= SHIFT;
        end
        SHIFT: begin
          x_q   <= shift_x_d;
          a_q   <= {x_q, a_q[WIDTH-1:1]};
          b_q   <= {a_q[0], b_q[WIDTH-1:1]};
          cnt_q <= cnt_q + 3'd1;
          if (cnt_q == ITER_LAST) begin
            state_q <= DONE;
            busy_q  <= 1'b0;
          end else begin
            state_q <= ADD;
          end
        end
        DONE: begin
          // Run must drop before another multiplication can start.
          if (!bus.Run) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Aval = a_q;
  assign bus.Bval = b_q;
  assign bus.Xval = x_q;
  assign bus.Busy = busy_q;

endmodule

// File: tb/tb_mult8_shift_add.sv
// Directed-vector bench for mult8_shift_add; expectations follow MULT_SIGNED_EN.
module tb_mult8_shift_add;

`ifdef MULT_SIGNED_EN
  localparam bit SGN = 1'b1;
`else
  localparam bit SGN = 1'b0;
`endif

  typedef struct {
    logic [7:0] b;
    logic [7:0] s;
    logic [7:0] ea;
    logic [7:0] eb;
    logic       ex;
  } vec_t;

  logic Clk = 1'b0;
  logic Reset;
  int   n_vec = 0;
  int   n_err = 0;
  int   lat;

  mult8_shift_add_if bus ();

  mult8_shift_add dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  task automatic load_b(input logic [7:0] b);
    bus.S            = b;
    bus.ClearA_LoadB = 1'b1;
    step();
    bus.ClearA_LoadB = 1'b0;
    chk("loadB_B", int'(bus.Bval), int'(b));
    chk("loadB_A", int'(bus.Aval), 0);
  endtask

  // Raises Run, then counts edges until Busy falls (bounded).
  task automatic run_mult(input logic [7:0] s, output int cycles);
    bus.S   = s;
    bus.Run = 1'b1;
    step();
    chk("busy_start", int'(bus.Busy), 1);
    cycles = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      cycles++;
      if (!bus.Busy) break;
    end
  endtask

  vec_t vecs [6];

  initial begin
    vecs[0] = '{8'hFD, 8'h07, SGN ? 8'hFF : 8'h06, 8'hEB, SGN};
    vecs[1] = '{8'h80, 8'h80, 8'h40, 8'h00, 1'b0};
    vecs[2] = '{8'hFF, 8'hFF, SGN ? 8'h00 : 8'hFE, 8'h01, 1'b0};
    vecs[3] = '{8'h03, 8'h05, 8'h00, 8'h0F, 1'b0};
    vecs[4] = '{8'h02, 8'hFE, SGN ? 8'hFF : 8'h01, 8'hFC, SGN};
    vecs[5] = '{8'h05, 8'h0C, 8'h00, 8'h3C, 1'b0};

    Reset            = 1'b1;
    bus.Run          = 1'b0;
    bus.ClearA_LoadB = 1'b0;
    bus.S            = 8'h00;
    step();
    step();
    chk("rst_A", int'(bus.Aval), 0);
    chk("rst_B", int'(bus.Bval), 0);
    chk("rst_X", int'(bus.Xval), 0);
    chk("rst_Busy", int'(bus.Busy), 0);
    Reset = 1'b0;

    for (int unsigned i = 0; i < 6; i++) begin
      load_b(vecs[i].b);
      run_mult(vecs[i].s, lat);
      chk("latency", lat, 17);
      chk("prod_A", int'(bus.Aval), int'(vecs[i].ea));
      chk("prod_B", int'(bus.Bval), int'(vecs[i].eb));
      chk("prod_X", int'(bus.Xval), int'(vecs[i].ex));
      bus.Run = 1'b0;
      step();
    end

    // Run held high: one product only; ClearA_LoadB in DONE is ignored.
    load_b(8'h03);
    run_mult(8'h05, lat);
    chk("hold_latency", lat, 17);
    for (int i = 0; i < 60; i++) begin
      bus.ClearA_LoadB = (i == 10);
      bus.S            = (i >= 10) ? 8'hAA : 8'h05;
      step();
    end
    bus.ClearA_LoadB = 1'b0;
    chk("hold_Busy", int'(bus.Busy), 0);
    chk("hold_A", int'(bus.Aval), 8'h00);
    chk("hold_B", int'(bus.Bval), 8'h0F);
    bus.Run = 1'b0;
    step();
    // Second Run multiplies the new M by the previous low byte.
    run_mult(8'h02, lat);
    chk("chain_latency", lat, 17);
    chk("chain_A", int'(bus.Aval), 8'h00);
    chk("chain_B", int'(bus.Bval), 8'h1E);
    bus.Run = 1'b0;
    step();

    // S changes and ClearA_LoadB during the operation must not disturb it.
    load_b(8'hFD);
    bus.S   = 8'h07;
    bus.Run = 1'b1;
    step();
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      if (k == 5) bus.S = 8'h55;
      if (k == 8) bus.ClearA_LoadB = 1'b1;
      step();
      lat++;
      if (!bus.Busy) break;
    end
    bus.ClearA_LoadB = 1'b0;
    chk("dist_latency", lat, 17);
    chk("dist_A", int'(bus.Aval), SGN ? 8'hFF : 8'h06);
    chk("dist_B", int'(bus.Bval), 8'hEB);
    chk("dist_X", int'(bus.Xval), int'(SGN));
    bus.Run = 1'b0;
    step();

    // Reset mid-operation.
    load_b(8'h11);
    bus.S   = 8'h09;
    bus.Run = 1'b1;
    step();
    repeat (9) step();
    chk("mid_Busy", int'(bus.Busy), 1);
    Reset = 1'b1;
    step();
    chk("mrst_A", int'(bus.Aval), 0);
    chk("mrst_B", int'(bus.Bval), 0);
    chk("mrst_X", int'(bus.Xval), 0);
    chk("mrst_Busy", int'(bus.Busy), 0);
    Reset            = 1'b0;
    bus.Run          = 1'b0;
    bus.S            = 8'h02;
    bus.ClearA_LoadB = 1'b1;
    step();
    bus.ClearA_LoadB = 1'b0;
    chk("post_rst_B", int'(bus.Bval), 8'h02);
    chk("post_rst_Busy", int'(bus.Busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
